// File: rtl/sram_like_arbiter_2x1.sv
// sram_like_arbiter_2x1: shares one SRAM-like master port between the
// instruction-refill requester and the data requester. One transaction may be
// outstanding at a time. Data wins arbitration unless instruction has already
// been passed over STARVE_LIMIT times in a row while it was waiting.
//
// Handshake semantics (all three SRAM-like ports): a requester raises req with
// stable wr/size/addr/wdata and holds them until addr_ok is seen in the same
// cycle (request accepted). Exactly one data_ok pulse later returns the
// response; rdata is meaningful only in the data_ok cycle.
module sram_like_arbiter_2x1 #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic             aclk,
  input  logic             aresetn,
  // instruction requester
  input  logic             inst_req,
  input  logic             inst_wr,
  input  logic [1:0]       inst_size,
  input  logic [31:0]      inst_addr,
  input  logic [31:0]      inst_wdata,
  output logic             inst_addr_ok,
  output logic             inst_data_ok,
  output logic [31:0]      inst_rdata,
  // data requester
  input  logic             data_req,
  input  logic             data_wr,
  input  logic [1:0]       data_size,
  input  logic [31:0]      data_addr,
  input  logic [31:0]      data_wdata,
  output logic             data_addr_ok,
  output logic             data_data_ok,
  output logic [31:0]      data_rdata,
  // shared master port
  output logic             m_req,
  output logic             m_wr,
  output logic [1:0]       m_size,
  output logic [31:0]      m_addr,
  output logic [31:0]      m_wdata,
  input  logic             m_addr_ok,
  input  logic             m_data_ok,
  input  logic [31:0]      m_rdata,
  // debug visibility of the arbitration state
  output logic [1:0]       dbg_state_o,
  output logic             dbg_owner_o,
  output logic [CNT_W-1:0] dbg_starve_cnt_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  localparam logic OWN_DATA = 1'b0;
  localparam logic OWN_INST = 1'b1;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [1:0]       state_q, state_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             owner_req;

  // The current owner's request line; only meaningful outside IDLE.
  assign owner_req = (owner_q == OWN_INST) ? inst_req : data_req;

  // State register: state, owner and starvation counter.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= S_IDLE;
      owner_q  <= OWN_DATA;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

  // Next-state logic: grant in IDLE, wait for acceptance, wait for response.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    starve_d = starve_q;
    case (state_q)
      S_IDLE: begin
        if (data_req && (!inst_req || (starve_q < LIMIT))) begin
          owner_d = OWN_DATA;
          state_d = S_ADDR;
          // Count consecutive data wins only while instruction is waiting.
          if (inst_req) begin
            starve_d = (starve_q >= LIMIT) ? LIMIT : starve_q + CNT_W'(1);
          end else begin
            starve_d = '0;
          end
        end else if (inst_req) begin
          owner_d  = OWN_INST;
          state_d  = S_ADDR;
          starve_d = '0;
        end
      end
      S_ADDR: begin
        // A withdrawn request abandons the grant without touching the counter.
        if (!owner_req) begin
          state_d = S_IDLE;
        end else if (m_addr_ok) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (m_data_ok) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output logic: master-port mux and handshake routing to the owner only.
  always_comb begin
    m_req        = 1'b0;
    m_wr         = 1'b0;
    m_size       = 2'd0;
    m_addr       = 32'd0;
    m_wdata      = 32'd0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    if ((state_q == S_ADDR) || (state_q == S_DATA)) begin
      if (owner_q == OWN_INST) begin
        m_wr    = inst_wr;
        m_size  = inst_size;
        m_addr  = inst_addr;
        m_wdata = inst_wdata;
      end else begin
        m_wr    = data_wr;
        m_size  = data_size;
        m_addr  = data_addr;
        m_wdata = data_wdata;
      end
    end
    if (state_q == S_ADDR) begin
      m_req = owner_req;
      if (owner_q == OWN_INST) begin
        inst_addr_ok = m_addr_ok & owner_req;
      end else begin
        data_addr_ok = m_addr_ok & owner_req;
      end
    end
    if (state_q == S_DATA) begin
      if (owner_q == OWN_INST) begin
        inst_data_ok = m_data_ok;
      end else begin
        data_data_ok = m_data_ok;
      end
    end
  end

  // Read data is broadcast; each requester qualifies it with its own data_ok.
  assign inst_rdata = m_rdata;
  assign data_rdata = m_rdata;

  assign dbg_state_o      = state_q;
  assign dbg_owner_o      = owner_q;
  assign dbg_starve_cnt_o = starve_q;

endmodule

// File: doc/sram_like_arbiter_2x1.md
Name: sram_like_arbiter_2x1

Overview:
- Shares one SRAM-like master port (req/wr/size/addr/wdata → addr_ok/data_ok/rdata) between the instruction-cache refill path and the data path.
- Sits between the two cache-side requesters and the AXI conversion interface.
- Allows one outstanding transaction; data has priority, with a bounded-starvation guarantee for instruction fetch.

Parameters:
- STARVE_LIMIT, 4, maximum consecutive data grants while an instruction request is pending before instruction is forced.
- CNT_W, 3, width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, asynchronous, active-low
- inst_req  in  1  instruction requester: request
- inst_wr  in  1  instruction requester: write
- inst_size  in  2  instruction requester: size
- inst_addr  in  32  instruction requester: address
- inst_wdata  in  32  instruction requester: write data
- inst_addr_ok  out  1  request accepted (instruction)
- inst_data_ok  out  1  response valid (instruction)
- inst_rdata  out  32  read data (instruction)
- data_req, data_wr, data_size, data_addr, data_wdata  in  1/1/2/32/32  data requester, same meaning as the instruction group
- data_addr_ok, data_data_ok  out  1/1  data requester handshakes
- data_rdata  out  32  read data (data)
- m_req, m_wr  out  1/1  master port request and write
- m_size  out  2  master port size
- m_addr, m_wdata  out  32/32  master port address and write data
- m_addr_ok, m_data_ok  in  1/1  master port handshakes
- m_rdata  in  32  master port read data

Behaviour:
- Clock and reset: single clock domain aclk. Reset is asynchronous assertion on aresetn low; all state registers take their reset values immediately.
- Reset state:
  - state=IDLE, owner=DATA, starve_cnt=0.
  - All outputs are 0 except the rdata buses: m_req=0; all addr_ok/data_ok=0; m_wr/m_size/m_addr/m_wdata=0.
- States:
  - IDLE: no owner active.
  - ADDR: the owner's request is presented on the master port, awaiting m_addr_ok.
  - DATA: accepted, awaiting m_data_ok.
- IDLE, at the clock edge, grant decision:
  - If data_req and (!inst_req or starve_cnt<STARVE_LIMIT): owner←DATA.
  - Else if inst_req: owner←INST.
  - Any grant moves to ADDR.
  - No request: stay in IDLE.
  - Grant latency: a request first seen in cycle N drives m_req in cycle N+1.
- Starvation counter, updated on each grant:
  - DATA granted while inst_req=1: starve_cnt+1, saturating at STARVE_LIMIT.
  - INST granted: cleared to 0.
  - DATA granted with inst_req=0: cleared to 0.
- ADDR outputs:
  - m_req = owner's req.
  - m_wr/m_size/m_addr/m_wdata are muxed combinationally from the owner.
  - owner_addr_ok = m_addr_ok & owner_req; the non-owner's addr_ok=0.
- ADDR transitions:
  - m_addr_ok & owner_req: go to DATA.
  - Owner drops req before acceptance: return to IDLE. No transaction is issued and starve_cnt is unchanged.
- DATA:
  - m_req=0; the other outputs hold the owner's mux.
  - owner_data_ok = m_data_ok. On m_data_ok, go to IDLE.
  - The non-owner's data_ok is always 0.
- Back-to-back: data_ok in cycle N lets IDLE re-arbitrate at edge N+1. Minimum issue spacing is therefore 1 idle cycle between transactions.
- m_data_ok while in IDLE or ADDR: protocol error, ignored. No data_ok is forwarded.
- m_addr_ok while m_req=0: ignored.
- Non-owner requests are held off with addr_ok=0; the requester keeps req asserted per SRAM-like rules.
- rdata: inst_rdata = data_rdata = m_rdata at all times. Validity is qualified only by each port's data_ok.
- Reset mid-transaction: state returns to IDLE immediately. Any in-flight master response after reset is dropped by the IDLE ignore rule.
- All datapath muxes are purely combinational from registered state and owner; there is no combinational path from m_* handshakes to the grant.

Test Plan:
- Single data read, default STARVE_LIMIT=4:
  - Stimulus: data_req=1, addr=0x1FC0_0010, wr=0; slave asserts addr_ok one cycle after m_req, and data_ok 3 cycles later with rdata=0xDEAD_BEEF.
  - Required: m_req rises 1 cycle after data_req; data_addr_ok pulses once; data_data_ok pulses once with data_rdata=0xDEAD_BEEF; inst_* handshakes stay 0.
- Simultaneous requests:
  - Stimulus: inst_req and data_req both held from the cycle after reset; slave has zero-wait addr_ok and 1-cycle data_ok.
  - Required: grant sequence D,D,D,D,I,D,D,D,D,I…; starve_cnt reaches 4 before each I grant.
- Write passthrough:
  - Stimulus: data write, wr=1, size=2, addr=0xBFAF_8000, wdata=0x1234_5678.
  - Required: the master port presents identical values while m_req=1.
  - Required: data_data_ok is asserted only on m_data_ok.
- Withdrawn request:
  - Stimulus: inst_req granted, then dropped in ADDR with m_addr_ok=0.
  - Required: next cycle IDLE, m_req=0, no inst handshakes, starve_cnt unchanged.
- Async reset mid-DATA:
  - Stimulus: assert aresetn=0 between clock edges while in DATA.
  - Required: m_req=0 and all ok outputs 0 immediately.
  - Required: a later m_data_ok=1 produces no inst/data data_ok.
- Spurious m_data_ok:
  - Stimulus: m_data_ok=1 while in IDLE.
  - Required: inst_data_ok=data_data_ok=0; state remains IDLE.
